cla12: RTL and testbench

- 12-bit two-level carry-lookahead adder with a registered output stage.
- Computes sum = a + b + cin, plus carry-out.
- Used as a standalone arithmetic block in the datapath.
- No ripple-carry chain anywhere; carries are computed by lookahead logic only.

---
 rtl/cla_pkg.sv | 11 +
 rtl/cla12_if.sv | 22 ++
 rtl/cla4_block.sv | 43 ++++
 rtl/cla12.sv | 64 ++++++
 tb/tb_cla12.sv | 135 +++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the 12-bit carry-lookahead adder.
// Imported by the interface, the 4-bit lookahead block and the top.
package cla_pkg;

   localparam int CLA_WIDTH   = 12;
   localparam int CLA_GROUP   = 4;
   localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

   typedef logic [CLA_WIDTH-1:0] cla_opnd_t;

endpackage

// File: rtl/cla12_if.sv
// Operand/result bundle for cla12.
// master: drives a, b, cin; reads sum, cout. slave: the adder side.
interface cla12_if;
   import cla_pkg::*;

   cla_opnd_t a;
   cla_opnd_t b;
   logic      cin;
   cla_opnd_t sum;
   logic      cout;

   modport master (
      output a, b, cin,
      input  sum, cout
   );

   modport slave (
      input  a, b, cin,
      output sum, cout
   );

endinterface

// File: rtl/cla4_block.sv
// 4-bit lookahead group: flattened in-group carries from ci.
// In: a, b, ci. Out: s, group propagate pg, group generate gg.
module cla4_block
   import cla_pkg::*;
(
   input  logic [CLA_GROUP-1:0] a,
   input  logic [CLA_GROUP-1:0] b,
   input  logic                 ci,
   output logic [CLA_GROUP-1:0] s,
   output logic                 pg,
   output logic                 gg
);

   logic [3:0] p;
   logic [3:0] g;
   logic       c1;
   logic       c2;
   logic       c3;

   assign p = a ^ b;
   assign g = a & b;

   // Every carry is a flat sum-of-products of ci; no chaining.
   assign c1 = g[0]
             | (p[0] & ci);
   assign c2 = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & ci);
   assign c3 = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);

   assign s = p ^ {c3, c2, c1, ci};

   // pg/gg ignore ci so the second level can precompute them.
   assign pg = &p;
   assign gg = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla12.sv
// 12-bit two-level carry-lookahead adder, registered result.
// Ports: clk, rst_n (sync, active-low), bus (a, b, cin -> sum, cout).
module cla12
   import cla_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   cla12_if.slave  bus
);

   logic [CLA_NGROUPS-1:0] pg;
   logic [CLA_NGROUPS-1:0] gg;
   logic [CLA_NGROUPS-1:0] gci;
   cla_opnd_t              s;
   logic                   c4;
   logic                   c8;

   cla_opnd_t              sum_d;
   cla_opnd_t              sum_q;
   logic                   cout_d;
   logic                   cout_q;

   // Second level: group carries are flat products of cin.
   assign c4 = gg[0]
             | (pg[0] & bus.cin);
   assign c8 = gg[1]
             | (pg[1] & gg[0])
             | (pg[1] & pg[0] & bus.cin);

   assign gci = {c8, c4, bus.cin};

   for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_grp
      cla4_block u_blk (
         .a  (bus.a[k*CLA_GROUP +: CLA_GROUP]),
         .b  (bus.b[k*CLA_GROUP +: CLA_GROUP]),
         .ci (gci[k]),
         .s  (s[k*CLA_GROUP +: CLA_GROUP]),
         .pg (pg[k]),
         .gg (gg[k])
      );
   end

   always_comb begin
      sum_d  = s;
      cout_d = gg[2]
             | (pg[2] & gg[1])
             | (pg[2] & pg[1] & gg[0])
             | (pg[2] & pg[1] & pg[0] & bus.cin);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_cla12.sv
// Randomized bench for cla12 against a 13-bit behavioural add.
// Directed vectors also pin hand-computed literal results.
module tb_cla12;
   import cla_pkg::*;

   logic clk;
   logic rst_n;

   cla12_if bus ();

   cla12 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [12:0] exp_q;
   logic        exp_valid = 1'b0;
   logic        lit_req;
   logic [12:0] lit_exp;
   logic        lit_arm = 1'b0;
   logic [12:0] lit_exp_q;

   // Reference: reset gives 0, otherwise the plain 13-bit sum.
   always @(posedge clk) begin
      exp_valid <= 1'b1;
      if (!rst_n)
         exp_q <= 13'd0;
      else
         exp_q <= {1'b0, bus.a} + {1'b0, bus.b} + {12'd0, bus.cin};
      lit_arm   <= lit_req;
      lit_exp_q <= lit_exp;
   end

   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         if ({bus.cout, bus.sum} !== exp_q) begin
            errors++;
            $display("FAIL model: got cout=%0d sum=%0d, want cout=%0d sum=%0d",
                     bus.cout, bus.sum, exp_q[12], exp_q[11:0]);
         end
      end
      if (lit_arm) begin
         checks++;
         if ({bus.cout, bus.sum} !== lit_exp_q) begin
            errors++;
            $display("FAIL literal: got cout=%0d sum=%0d, want cout=%0d sum=%0d",
                     bus.cout, bus.sum, lit_exp_q[12], lit_exp_q[11:0]);
         end
      end
   end

   task automatic drive(input logic r, input logic [11:0] ia,
                        input logic [11:0] ib, input logic ic,
                        input logic lit, input logic [12:0] le);
      @(posedge clk);
      #1;
      rst_n   = r;
      bus.a   = ia;
      bus.b   = ib;
      bus.cin = ic;
      lit_req = lit;
      lit_exp = le;
   endtask

   logic [11:0] va [5];
   logic [11:0] vb [5];
   logic [12:0] vs [5];

   initial begin
      rst_n   = 1'b0;
      bus.a   = 12'hFFF;
      bus.b   = 12'd1;
      bus.cin = 1'b0;
      lit_req = 1'b0;
      lit_exp = 13'd0;

      va = '{12'd0, 12'd15, 12'd12, 12'd7,   12'd11};
      vb = '{12'd0, 12'd1795, 12'd14, 12'd353, 12'd3311};
      vs = '{13'd0, 13'd1810, 13'd26, 13'd360, 13'd3322};

      // Two reset edges with operands that would otherwise carry out.
      drive(1'b0, 12'hFFF, 12'd1, 1'b0, 1'b1, 13'd0);
      drive(1'b1, 12'hFFF, 12'd1, 1'b0, 1'b1, 13'h1000);

      for (int i = 0; i < 5; i++)
         drive(1'b1, va[i], vb[i], 1'b0, 1'b1, vs[i]);
      for (int i = 0; i < 5; i++)
         drive(1'b1, va[i], vb[i], 1'b1, 1'b1, vs[i] + 13'd1);

      drive(1'b1, 12'd15,   12'd1,    1'b0, 1'b1, 13'd16);
      drive(1'b1, 12'd255,  12'd1,    1'b0, 1'b1, 13'd256);
      drive(1'b1, 12'd2047, 12'd2048, 1'b1, 1'b1, 13'h1000);
      drive(1'b1, 12'd4095, 12'd4095, 1'b1, 1'b1, 13'h1FFF);
      drive(1'b1, 12'd4095, 12'd4095, 1'b0, 1'b1, 13'h1FFE);

      // Operands change mid-cycle; only the value at the edge counts.
      drive(1'b1, 12'd1, 12'd1, 1'b0, 1'b1, 13'd123);
      #2;
      bus.a = 12'd100;
      bus.b = 12'd23;

      // Back-to-back stream with a one-edge reset in the middle.
      for (int i = 0; i < 8; i++)
         drive(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'b0, 13'd0);
      drive(1'b0, 12'hABC, 12'h543, 1'b1, 1'b1, 13'd0);
      drive(1'b1, 12'd1000, 12'd24, 1'b0, 1'b1, 13'd1024);
      for (int i = 0; i < 8; i++)
         drive(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'b0, 13'd0);

      for (int i = 0; i < 10000; i++)
         drive(1'b1, 12'($urandom), 12'($urandom), 1'($urandom), 1'b0, 13'd0);

      drive(1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 13'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
